// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/writeback control sequencer for the regfile/ALU datapath.
module instr_sequencer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [15:0]       mem_rdata,
  input  logic [4:0]        flags,
  output logic [15:0]       reg_en,
  output logic [3:0]        reg_a_sel,
  output logic [3:0]        reg_b_sel,
  output logic [7:0]        alu_op,
  output logic [3:0]        imm,
  output logic              busy,
  output logic              halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, HALT} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic [15:0] ir;
  logic [4:0] op, dop;
  logic wr, unused;
  assign dop = mem_rdata[15:11];
  assign op = ir[15:11];
  assign wr = op <= 5'h17 && op != 5'h0A && op != 5'h0B && op != 5'h0C && op != 5'h17;
  assign mem_addr = pc;
  assign mem_rd_en = state == FETCH;
  assign busy = state == FETCH || state == DECODE || state == EXEC || state == WB;
  assign halted = state == HALT;
  // gated by reset so an in-flight write is dropped as soon as reset is seen
  assign reg_en = (reset && state == WB && wr) ? 16'h1 << ir[7:4] : 16'h0;
  assign unused = ^{flags[3:0], ir[10:8], ir[3:0], mem_rdata[10:8]};
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pc <= '0;
      ir <= '0;
      reg_a_sel <= '0;
      reg_b_sel <= '0;
      imm <= '0;
      alu_op <= 8'h17;
    end else begin
      case (state)
        IDLE: if (start) state <= FETCH;
        FETCH: state <= DECODE;
        DECODE: begin
          ir <= mem_rdata;
          if (dop == 5'h1F) begin
            state <= HALT;
            pc <= '0;
            reg_a_sel <= '0;
            reg_b_sel <= '0;
            imm <= '0;
            alu_op <= 8'h17;
          end else if (dop == 5'h1D) begin
            state <= FETCH;
            pc <= flags[4] ? pc + ADDR_W'(2) : pc + ADDR_W'(1);
          end else begin
            state <= EXEC;
            reg_a_sel <= mem_rdata[7:4];
            reg_b_sel <= mem_rdata[3:0];
            imm <= mem_rdata[3:0];
            alu_op <= dop <= 5'h17 ? {3'b000, dop} : 8'h17;
          end
        end
        EXEC: state <= WB;
        WB: begin
          state <= FETCH;
          pc <= pc + ADDR_W'(1);
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
